dnn_neigh_aggr: RTL and testbench

//  Neighbour-aggregation stage between layer-1 and the output layer of the dnn datapath.

---
 rtl/dnn_neigh_aggr.sv | 141 ++++++++++++++
 tb/tb_dnn_neigh_aggr.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dnn_neigh_aggr.sv
// Neighbour-aggregation stage: buffers per-node ReLU vectors and sums a target
// node with its adjacency-mask neighbours, one node per cycle, saturating to AGGR_W.
module dnn_neigh_aggr #(
  parameter int NUM_NODES = 4,
  parameter int NODE_W    = 2,
  parameter int FEAT_W    = 13,
  parameter int AGGR_W    = 15
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 relu_valid,
  input  logic [NODE_W-1:0]    relu_node_id,
  input  logic [FEAT_W-1:0]    y4_relu_p4,
  input  logic [FEAT_W-1:0]    y5_relu_p4,
  input  logic [FEAT_W-1:0]    y6_relu_p4,
  input  logic [FEAT_W-1:0]    y7_relu_p4,
  input  logic                 flush,
  input  logic                 aggr_req,
  input  logic [NODE_W-1:0]    aggr_node_id,
  input  logic [NUM_NODES-1:0] adj_mask,
  output logic                 aggr_ready,
  output logic                 aggr_valid,
  output logic                 aggr_miss,
  output logic [AGGR_W-1:0]    y4_aggr_p4,
  output logic [AGGR_W-1:0]    y5_aggr_p4,
  output logic [AGGR_W-1:0]    y6_aggr_p4,
  output logic [AGGR_W-1:0]    y7_aggr_p4
);

  localparam int LANES = 4;
  localparam int ACC_W = AGGR_W + 1;

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t                   state_q, state_d;
  logic [FEAT_W-1:0]        feat_mem [NUM_NODES][LANES];
  logic [FEAT_W-1:0]        relu_in  [LANES];
  logic [NUM_NODES-1:0]     buf_vld_q, buf_vld_d;
  logic [NUM_NODES-1:0]     sel_q;
  logic [NODE_W-1:0]        idx_q;
  logic signed [ACC_W-1:0]  acc_q [LANES];
  logic                     miss_q;
  logic [AGGR_W-1:0]        y_q   [LANES];

  assign relu_in[0] = y4_relu_p4;
  assign relu_in[1] = y5_relu_p4;
  assign relu_in[2] = y6_relu_p4;
  assign relu_in[3] = y7_relu_p4;

  // Overflow at ACC_W bits shows up as the two top bits disagreeing.
  function automatic logic [AGGR_W-1:0] clamp(input logic signed [ACC_W-1:0] a);
    if (a[ACC_W-1] != a[ACC_W-2])
      return a[ACC_W-1] ? {1'b1, {(AGGR_W-1){1'b0}}} : {1'b0, {(AGGR_W-1){1'b1}}};
    return a[AGGR_W-1:0];
  endfunction

  // NOTE: feature storage has no reset; its valid bits alone say whether an entry is usable.
  always_ff @(posedge clk) begin
    if (relu_valid) begin
      for (int l = 0; l < LANES; l++) feat_mem[relu_node_id][l] <= relu_in[l];
    end
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    buf_vld_d = buf_vld_q;
    if (flush) buf_vld_d = '0;
    if (relu_valid) buf_vld_d[relu_node_id] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) buf_vld_q <= '0;
    else        buf_vld_q <= buf_vld_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (aggr_req) state_d = ACCUM;
      ACCUM:   if (idx_q == NODE_W'(NUM_NODES - 1)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      sel_q      <= '0;
      idx_q      <= '0;
      miss_q     <= 1'b0;
      aggr_valid <= 1'b0;
      aggr_miss  <= 1'b0;
      for (int l = 0; l < LANES; l++) begin
        acc_q[l] <= '0;
        y_q[l]   <= '0;
      end
    end else begin
      state_q    <= state_d;
      aggr_valid <= 1'b0;
      aggr_miss  <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (aggr_req) begin
            sel_q  <= adj_mask | (NUM_NODES'(1) << aggr_node_id);
            idx_q  <= '0;
            miss_q <= 1'b0;
            for (int l = 0; l < LANES; l++) acc_q[l] <= '0;
          end
        end
        ACCUM: begin
          // Reads the pre-edge buffer, so a write to this node on the same edge is not seen.
          if (sel_q[idx_q]) begin
            if (buf_vld_q[idx_q]) begin
              for (int l = 0; l < LANES; l++)
                acc_q[l] <= acc_q[l] + {{(ACC_W-FEAT_W){feat_mem[idx_q][l][FEAT_W-1]}},
                                        feat_mem[idx_q][l]};
            end else begin
              miss_q <= 1'b1;
            end
          end
          idx_q <= idx_q + 1'b1;
        end
        DONE: begin
          aggr_valid <= 1'b1;
          aggr_miss  <= miss_q;
          for (int l = 0; l < LANES; l++) y_q[l] <= clamp(acc_q[l]);
        end
        default: ;
      endcase
    end
  end

  assign aggr_ready = (state_q == IDLE);
  assign y4_aggr_p4 = y_q[0];
  assign y5_aggr_p4 = y_q[1];
  assign y6_aggr_p4 = y_q[2];
  assign y7_aggr_p4 = y_q[3];

endmodule

// File: tb/tb_dnn_neigh_aggr.sv
// Scoreboard bench for dnn_neigh_aggr: a cycle-counting reference model pushes expected
// results; a negedge monitor pops and compares whenever aggr_valid is seen.
module tb_dnn_neigh_aggr;

  localparam int N      = 4;
  localparam int NODE_W = 2;
  localparam int FEAT_W = 13;
  localparam int AGGR_W = 15;
  localparam int AMAX   = (1 << (AGGR_W - 1)) - 1;
  localparam int AMIN   = -(1 << (AGGR_W - 1));

  logic                     clk = 1'b0;
  logic                     rst_n = 1'b0;
  logic                     relu_valid = 1'b0;
  logic [NODE_W-1:0]        relu_node_id = '0;
  logic [FEAT_W-1:0]        relu_y [4];
  logic                     flush = 1'b0;
  logic                     aggr_req = 1'b0;
  logic [NODE_W-1:0]        aggr_node_id = '0;
  logic [N-1:0]             adj_mask = '0;
  logic                     aggr_ready, aggr_valid, aggr_miss;
  logic signed [AGGR_W-1:0] y_aggr [4];

  dnn_neigh_aggr dut (
    .clk(clk), .rst_n(rst_n),
    .relu_valid(relu_valid), .relu_node_id(relu_node_id),
    .y4_relu_p4(relu_y[0]), .y5_relu_p4(relu_y[1]),
    .y6_relu_p4(relu_y[2]), .y7_relu_p4(relu_y[3]),
    .flush(flush), .aggr_req(aggr_req), .aggr_node_id(aggr_node_id), .adj_mask(adj_mask),
    .aggr_ready(aggr_ready), .aggr_valid(aggr_valid), .aggr_miss(aggr_miss),
    .y4_aggr_p4(y_aggr[0]), .y5_aggr_p4(y_aggr[1]),
    .y6_aggr_p4(y_aggr[2]), .y7_aggr_p4(y_aggr[3])
  );

  always #5 clk = ~clk;

  typedef struct {
    int y [4];
    bit miss;
    int cyc;
  } exp_t;

  exp_t exp_q [$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;

  // Reference model state: buffer contents plus progress of the request in flight.
  int       m_feat [N][4];
  bit [N-1:0] m_vld = '0;
  bit       m_busy = 1'b0;
  int       m_cnt;
  bit [N-1:0] m_sel;
  int       m_acc [4];
  bit       m_miss;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int sat(input int v);
    if (v > AMAX) return AMAX;
    if (v < AMIN) return AMIN;
    return v;
  endfunction

  // Applies the behavioural rules for one active edge, using the inputs held across it.
  task automatic model_edge();
    exp_t e;
    if (m_busy) begin
      if (m_cnt < N) begin
        if (m_sel[m_cnt]) begin
          if (m_vld[m_cnt]) for (int l = 0; l < 4; l++) m_acc[l] += m_feat[m_cnt][l];
          else m_miss = 1'b1;
        end
        m_cnt++;
      end else begin
        for (int l = 0; l < 4; l++) e.y[l] = sat(m_acc[l]);
        e.miss = m_miss;
        e.cyc  = cyc;
        exp_q.push_back(e);
        m_busy = 1'b0;
      end
    end else if (aggr_req) begin
      m_busy = 1'b1;
      m_cnt  = 0;
      m_sel  = adj_mask | (N'(1) << aggr_node_id);
      m_miss = 1'b0;
      for (int l = 0; l < 4; l++) m_acc[l] = 0;
    end
    if (flush) m_vld = '0;
    if (relu_valid) begin
      for (int l = 0; l < 4; l++) m_feat[relu_node_id][l] = int'($signed(relu_y[l]));
      m_vld[relu_node_id] = 1'b1;
    end
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    model_edge();
    #1;
    check("ready", int'(aggr_ready), int'(!m_busy));
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    m_busy = 1'b0;
    m_vld  = '0;
    #1;
    check("rst_ready", int'(aggr_ready), 1);
    check("rst_valid", int'(aggr_valid), 0);
    check("rst_miss", int'(aggr_miss), 0);
    for (int l = 0; l < 4; l++) check($sformatf("rst_y%0d", l + 4), int'(y_aggr[l]), 0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic write_node(input int id, input int a, input int b, input int c, input int d);
    relu_valid   = 1'b1;
    relu_node_id = NODE_W'(id);
    relu_y[0] = FEAT_W'(a); relu_y[1] = FEAT_W'(b);
    relu_y[2] = FEAT_W'(c); relu_y[3] = FEAT_W'(d);
    step();
    relu_valid = 1'b0;
  endtask

  task automatic request(input int node, input int mask);
    aggr_req     = 1'b1;
    aggr_node_id = NODE_W'(node);
    adj_mask     = N'(mask);
    step();
    aggr_req = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 20 && m_busy; i++) step();
    if (m_busy) check("drain_timeout", 1, 0);
    step();
  endtask

  // Monitor: decoupled from stimulus, compares each pulse and output stability in between.
  initial begin
    int   last_y [4];
    exp_t e;
    for (int l = 0; l < 4; l++) last_y[l] = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        for (int l = 0; l < 4; l++) last_y[l] = 0;
      end else if (aggr_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_valid", 1, 0);
        end else begin
          e = exp_q.pop_front();
          for (int l = 0; l < 4; l++) begin
            check($sformatf("y%0d_aggr", l + 4), int'(y_aggr[l]), e.y[l]);
            last_y[l] = e.y[l];
          end
          check("miss", int'(aggr_miss), int'(e.miss));
          check("latency_cycle", cyc, e.cyc);
        end
      end else begin
        check("miss_idle", int'(aggr_miss), 0);
        for (int l = 0; l < 4; l++) check($sformatf("y%0d_hold", l + 4), int'(y_aggr[l]), last_y[l]);
      end
    end
  end

  initial begin
    for (int l = 0; l < 4; l++) relu_y[l] = '0;
    #2;
    apply_reset();

    // Empty buffer: target only, entry invalid.
    request(0, 0);
    wait_idle();

    write_node(0, 1, 2, 3, 4);
    write_node(2, 10, 20, 30, 40);
    request(0, 4'b0100);
    wait_idle();

    for (int n = 0; n < N; n++) write_node(n, 4095, 4095, 4095, 4095);
    request(1, 4'b1111);
    wait_idle();

    // Rewrites during ACCUM: node0 after its visit, node3 before its visit.
    request(1, 4'b1111);
    step();
    write_node(0, 100, 200, 300, 400);
    write_node(3, 5, 5, 5, 5);
    wait_idle();

    // Request held high while busy: the model only accepts it when idle.
    aggr_req = 1'b1; aggr_node_id = 2; adj_mask = 4'b1010;
    repeat (20) step();
    aggr_req = 1'b0;
    wait_idle();

    flush = 1'b1;
    step();
    flush = 1'b0;
    request(1, 4'b0001);
    wait_idle();

    // Reset in the middle of ACCUM aborts without a result.
    write_node(2, 7, 7, 7, 7);
    request(2, 4'b0000);
    step();
    step();
    apply_reset();
    repeat (10) step();
    request(2, 4'b0000);
    wait_idle();

    // Randomized traffic, including negative features and simultaneous flush/write.
    for (int i = 0; i < 600; i++) begin
      relu_valid   = ($urandom_range(0, 2) == 0);
      relu_node_id = NODE_W'($urandom_range(0, N - 1));
      for (int l = 0; l < 4; l++)
        relu_y[l] = ($urandom_range(0, 1) == 1) ? FEAT_W'($urandom_range(0, 4095))
                                                 : FEAT_W'($urandom);
      flush        = ($urandom_range(0, 15) == 0);
      aggr_req     = ($urandom_range(0, 1) == 1);
      aggr_node_id = NODE_W'($urandom_range(0, N - 1));
      adj_mask     = N'($urandom);
      step();
    end
    relu_valid = 1'b0; flush = 1'b0; aggr_req = 1'b0;
    wait_idle();
    step();
    check("queue_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
